// File: rtl/hc595_chain_drv.sv
// Serial driver for a daisy chain of 74HC595s: shifts a frame out on ds/shcp, then pulses stcp.
// Define HC595_OE_EN to add a PWM-dimmed output enable (i_duty, o_oe_n).
module hc595_chain_drv #(
  parameter int CHIPS     = 2,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*CHIPS-1:0]   i_din,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_shcp,
  output logic                 o_stcp,
  output logic                 o_ds,
`ifdef HC595_OE_EN
  input  logic [7:0]           i_duty,
  output logic                 o_oe_n,
`endif
  output logic [1:0]           o_dbg_state
);

  localparam int DW  = 8 * CHIPS;
  localparam int CW  = $clog2(DW + 1);
  localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  // Handshake: a frame is accepted on a rising clk edge where i_valid && o_ready;
  // o_ready is high only in IDLE, and i_din is sampled only at that edge.
  state_t          r_state, w_state;
  logic [DVW-1:0]  r_div, w_div;
  logic [CW-1:0]   r_bits, w_bits;
  logic [DW-1:0]   r_sr, w_sr;
  logic            r_ready, w_ready;
  logic            r_done, w_done;
  logic            r_shcp, w_shcp;
  logic            r_stcp, w_stcp;
  logic            r_ds, w_ds;
  logic            w_tick;
  logic            w_accept;

  assign w_tick   = (r_div == DVW'(DIV - 1));
  assign w_accept = i_valid && r_ready;

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bits  = r_bits;
    w_sr    = r_sr;
    w_ready = r_ready;
    w_done  = 1'b0;
    w_shcp  = r_shcp;
    w_stcp  = r_stcp;
    w_ds    = r_ds;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state = S_SHIFT;
          w_sr    = i_din;
          w_bits  = '0;
          w_div   = '0;
          w_shcp  = 1'b0;
          w_ready = 1'b0;
          w_ds    = (MSB_FIRST != 0) ? i_din[DW-1] : i_din[0];
        end
      end
      S_SHIFT: begin
        w_div = w_tick ? '0 : r_div + DVW'(1);
        if (w_tick) begin
          if (!r_shcp) begin
            w_shcp = 1'b1;
            w_bits = r_bits + CW'(1);
          end else begin
            w_shcp = 1'b0;
            // ds only moves on the falling shcp edge, centring it in the high phase.
            if (r_bits == CW'(DW)) begin
              w_stcp  = 1'b1;
              w_state = S_LATCH;
            end else if (MSB_FIRST != 0) begin
              w_sr = {r_sr[DW-2:0], 1'b0};
              w_ds = r_sr[DW-2];
            end else begin
              w_sr = {1'b0, r_sr[DW-1:1]};
              w_ds = r_sr[1];
            end
          end
        end
      end
      S_LATCH: begin
        w_div = w_tick ? '0 : r_div + DVW'(1);
        if (w_tick) begin
          w_stcp  = 1'b0;
          w_done  = 1'b1;
          w_ready = 1'b1;
          w_ds    = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_ready = 1'b1;
        w_shcp  = 1'b0;
        w_stcp  = 1'b0;
        w_ds    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div   <= '0;
      r_bits  <= '0;
      r_sr    <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_shcp  <= 1'b0;
      r_stcp  <= 1'b0;
      r_ds    <= 1'b0;
    end else begin
      r_div   <= w_div;
      r_bits  <= w_bits;
      r_sr    <= w_sr;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_shcp  <= w_shcp;
      r_stcp  <= w_stcp;
      r_ds    <= w_ds;
    end
  end

  assign o_ready     = r_ready;
  assign o_done      = r_done;
  assign o_shcp      = r_shcp;
  assign o_stcp      = r_stcp;
  assign o_ds        = r_ds;
  assign o_dbg_state = r_state;

`ifdef HC595_OE_EN
  logic [7:0] r_pwm_cnt;
  logic       r_armed;
  logic       r_oe_n;

  // Outputs stay dark until a complete frame has been latched since reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_armed   <= 1'b0;
      r_oe_n    <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_armed   <= r_armed | w_done;
      r_oe_n    <= !(r_armed && (r_pwm_cnt < i_duty));
    end
  end

  assign o_oe_n = r_oe_n;
`endif

endmodule

// File: tb/tb_hc595_chain_drv.sv
// Directed bench for hc595_chain_drv: an MSB-first and an LSB-first instance share stimulus,
// each feeding a behavioural 595 chain whose latched word is checked after every frame.
module tb_hc595_chain_drv;

  localparam int CHIPS   = 2;
  localparam int DIV     = 4;
  localparam int DW      = 8 * CHIPS;
  localparam int T_LATCH = 2 * DW * DIV;
  localparam int T_END   = (2 * DW + 1) * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] din;

  logic        m_ready, m_done, m_shcp, m_stcp, m_ds;
  logic        l_ready, l_done, l_shcp, l_stcp, l_ds;
  logic [1:0]  m_dbg, l_dbg;
`ifdef HC595_OE_EN
  logic [7:0]  duty = 8'd64;
  logic        m_oe_n, l_oe_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_chain = '0, m_latched = '0;
  logic [15:0] l_chain = '0, l_latched = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  hc595_chain_drv #(.CHIPS(CHIPS), .DIV(DIV), .MSB_FIRST(1)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_valid(valid),
    .o_ready(m_ready), .o_done(m_done), .o_shcp(m_shcp), .o_stcp(m_stcp), .o_ds(m_ds),
`ifdef HC595_OE_EN
    .i_duty(duty), .o_oe_n(m_oe_n),
`endif
    .o_dbg_state(m_dbg)
  );

  hc595_chain_drv #(.CHIPS(CHIPS), .DIV(DIV), .MSB_FIRST(0)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_valid(valid),
    .o_ready(l_ready), .o_done(l_done), .o_shcp(l_shcp), .o_stcp(l_stcp), .o_ds(l_ds),
`ifdef HC595_OE_EN
    .i_duty(duty), .o_oe_n(l_oe_n),
`endif
    .o_dbg_state(l_dbg)
  );

  // Board-level 595 chain models: last chip's register holds the first bit shifted.
  always @(posedge m_shcp) m_chain <= {m_chain[14:0], m_ds};
  always @(posedge m_stcp) m_latched <= m_chain;
  always @(posedge l_shcp) l_chain <= {l_chain[14:0], l_ds};
  always @(posedge l_stcp) l_latched <= l_chain;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [15:0] d);
    @(negedge clk);
    check("ready before accept", {m_ready, l_ready}, 2'b11);
    valid = 1'b1;
    din   = d;
    @(posedge clk);
  endtask

  // Called right after the accept edge; checks pin timing for t = 0..T_END.
  task automatic watch_frame(input string tag, input logic [15:0] exp_m, input logic [15:0] exp_l,
                             input bit busy_poke, input bit rst_mid, input bit hold,
                             input logic [15:0] next_din);
    logic [15:0] cap_m, cap_l;
    logic [3:0]  e;
    int          t;
    int          k;
    bit          stop;
    cap_m = '0;
    cap_l = '0;
    t     = 0;
    stop  = 1'b0;
    while (!stop && t <= T_END) begin
      @(negedge clk);
      e[3] = (t == T_END);
      e[2] = (t == T_END);
      e[1] = (t < T_LATCH) && (((t / DIV) % 2) == 1);
      e[0] = (t >= T_LATCH) && (t < T_END);
      check($sformatf("%s msb rdy/done/shcp/stcp t=%0d", tag, t), {m_ready, m_done, m_shcp, m_stcp}, e);
      check($sformatf("%s lsb rdy/done/shcp/stcp t=%0d", tag, t), {l_ready, l_done, l_shcp, l_stcp}, e);
      if ((t < T_LATCH) && ((t % (2 * DIV)) == DIV)) begin
        k = (t - DIV) / (2 * DIV);
        cap_m[15-k] = m_ds;
        cap_l[15-k] = l_ds;
      end
      if (t == T_END) check($sformatf("%s ds idle", tag), {m_ds, l_ds}, 2'b00);
      if (t == 0 && !hold) valid = 1'b0;
      if (busy_poke && t == 20) begin
        valid = 1'b1;
        din   = 16'hFFFF;
      end
      if (busy_poke && t == 21) begin
        valid = 1'b0;
        din   = 16'h0000;
      end
      if (hold && t == T_END) din = next_din;
      if (rst_mid && t == 60) begin
        #2 rst = 1'b1;
        #1;
        check($sformatf("%s async rst msb pins", tag), {m_ready, m_done, m_shcp, m_stcp, m_ds}, 5'b10000);
        check($sformatf("%s async rst lsb pins", tag), {l_ready, l_done, l_shcp, l_stcp, l_ds}, 5'b10000);
        stop = 1'b1;
      end
      t++;
    end
    if (!rst_mid) begin
      check($sformatf("%s msb ds at shcp rises", tag), cap_m, exp_m);
      check($sformatf("%s lsb ds at shcp rises", tag), cap_l, exp_l);
      check($sformatf("%s msb chain latched", tag), m_latched, exp_q.pop_front());
      check($sformatf("%s lsb chain latched", tag), l_latched, exp_l);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset msb pins", {m_ready, m_done, m_shcp, m_stcp, m_ds}, 5'b10000);
    check("reset lsb pins", {l_ready, l_done, l_shcp, l_stcp, l_ds}, 5'b10000);
`ifdef HC595_OE_EN
    check("reset oe_n", {m_oe_n, l_oe_n}, 2'b11);
`endif
    rst = 1'b0;

    // Frame A5C3 with a valid poke while busy that must be ignored.
    exp_q.push_back(16'hA5C3);
    start_frame(16'hA5C3);
    watch_frame("A5C3", 16'hA5C3, 16'hC3A5, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Reset mid-shift: no latch pulse, chips keep A5C3.
    start_frame(16'h1234);
    watch_frame("rst-mid", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    check("latched kept after rst msb", m_latched, 16'hA5C3);
    check("latched kept after rst lsb", l_latched, 16'hC3A5);

    exp_q.push_back(16'h0001);
    start_frame(16'h0001);
    watch_frame("0001", 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000);

    // valid held across two frames: second accept on the cycle after done.
    exp_q.push_back(16'h3C5A);
    exp_q.push_back(16'h8001);
    start_frame(16'h3C5A);
    watch_frame("3C5A", 16'h3C5A, 16'h5A3C, 1'b0, 1'b0, 1'b1, 16'h8001);
    @(posedge clk);
    watch_frame("8001", 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("scoreboard drained", exp_q.size(), 0);

`ifdef HC595_OE_EN
    begin
      int lows;
      lows = 0;
      repeat (256) begin
        @(negedge clk);
        if (!m_oe_n) lows++;
      end
      check("oe_n low count duty 64", lows, 64);
      duty = 8'd0;
      repeat (2) @(negedge clk);
      lows = 0;
      repeat (256) begin
        @(negedge clk);
        if (!m_oe_n || !l_oe_n) lows++;
      end
      check("oe_n low count duty 0", lows, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
